serial_denormalizer: RTL and testbench



---
 rtl/serial_denormalizer_pkg.sv | 21 ++
 rtl/serial_denormalizer_if.sv | 27 ++
 rtl/serial_denormalizer.sv | 105 ++++++++++
 tb/tb_serial_denormalizer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/serial_denormalizer_pkg.sv
// Shared encoding for the leading-one index path: FSM states, default widths
// and the "no leading one" index value.
package serial_denormalizer_pkg;

  localparam int WIDTH_DEF = 9;

  // Smallest signed width that holds every index from -1 up to WIDTH-1.
  function automatic int idx_w_for(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int IDX_W_DEF = idx_w_for(WIDTH_DEF);
  localparam int IDX_NONE  = -1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_denormalizer_if.sv
// Operand and result handshake bundle of the serial denormalizer.
interface serial_denormalizer_if #(
  parameter int WIDTH = 9,
  parameter int IDX_W = 5
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IDX_W-1:0] in_index;
  logic [WIDTH-2:0]        in_frac;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_value;
  logic                    out_inexact;
  logic                    out_err;

  modport master (
    output in_valid, in_index, in_frac, out_ready,
    input  in_ready, out_valid, out_value, out_inexact, out_err
  );

  modport slave (
    input  in_valid, in_index, in_frac, out_ready,
    output in_ready, out_valid, out_value, out_inexact, out_err
  );

endinterface

// File: rtl/serial_denormalizer.sv
// Rebuilds a WIDTH-bit unsigned value from a signed leading-one index plus the
// fraction bits below it, shifting right one bit per cycle.
module serial_denormalizer
  import serial_denormalizer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_denormalizer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic signed [IDX_W-1:0] L_IDX_MAX  = IDX_W'(WIDTH - 1);
  localparam logic signed [IDX_W-1:0] L_IDX_ZERO = IDX_W'(0);
  localparam logic signed [IDX_W-1:0] L_IDX_NONE = IDX_W'(IDX_NONE);

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sticky;
  logic               r_err;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_value;
  logic               r_out_inexact;
  logic               r_out_err;

  logic signed [IDX_W-1:0] w_idx;
  logic                    w_idx_legal;
  logic [IDX_W-1:0]        w_shift_amt;

  assign w_idx       = bus.in_index;
  assign w_idx_legal = (w_idx >= L_IDX_ZERO) && (w_idx <= L_IDX_MAX);
  assign w_shift_amt = L_IDX_MAX - w_idx;

  // Control FSM, shift register, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shreg       <= '0;
      r_cnt         <= '0;
      r_sticky      <= 1'b0;
      r_err         <= 1'b0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_value   <= '0;
      r_out_inexact <= 1'b0;
      r_out_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_state    <= ST_SHIFT;
            r_in_ready <= 1'b0;
            r_sticky   <= 1'b0;
            if (w_idx_legal) begin
              r_shreg <= {1'b1, bus.in_frac};
              r_cnt   <= CNT_W'(w_shift_amt);
              r_err   <= 1'b0;
            end else begin
              r_shreg <= '0;
              r_cnt   <= '0;
              r_err   <= (w_idx != L_IDX_NONE);
            end
          end
        end
        ST_SHIFT: begin
          if (r_cnt == '0) begin
            r_state       <= ST_DONE;
            r_out_valid   <= 1'b1;
            r_out_value   <= r_shreg;
            r_out_inexact <= r_sticky;
            r_out_err     <= r_err;
          end else begin
            r_sticky <= r_sticky | r_shreg[0];
            r_shreg  <= r_shreg >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          // New operands are only taken from IDLE, so a consume cycle never accepts.
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_value   = r_out_value;
  assign bus.out_inexact = r_out_inexact;
  assign bus.out_err     = r_out_err;

endmodule

// File: tb/tb_serial_denormalizer.sv
// Randomized and directed checks of serial_denormalizer against an arithmetic
// model of the denormalization (value, sticky bit, error flag, latency).
module tb_serial_denormalizer;

  localparam int W  = 9;
  localparam int IW = 5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_denormalizer_if #(.WIDTH(W), .IDX_W(IW)) bus ();

  serial_denormalizer #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: place the hidden one above the fraction, then drop the bits
  // that fall below the requested leading-one position.
  task automatic model(input int sidx, input int frac, output int val,
                       output int inx, output int err, output int lat);
    int full;
    int sh;
    if (sidx >= 0 && sidx <= W - 1) begin
      sh   = (W - 1) - sidx;
      full = (1 << (W - 1)) | frac;
      val  = full >> sh;
      inx  = ((full % (1 << sh)) != 0) ? 1 : 0;
      err  = 0;
      lat  = sh + 1;
    end else begin
      val = 0;
      inx = 0;
      err = (sidx == -1) ? 0 : 1;
      lat = 1;
    end
  endtask

  task automatic do_op(input logic [IW-1:0] idx, input logic [W-2:0] frac, input int hold);
    int val, inx, err, lat, sidx, seen;
    sidx = int'($signed(idx));
    model(sidx, int'(frac), val, inx, err, lat);
    check_eq("ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_index = idx;
    bus.in_frac  = frac;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_frac  = '1;
    check_eq("ready_low_after_accept", 32'(bus.in_ready), 32'd0);
    seen = 0;
    while (!bus.out_valid && seen < W + 4) begin
      @(posedge clk); #1;
      seen++;
    end
    check_eq("latency", 32'(seen), 32'(lat));
    check_eq("value", 32'(bus.out_value), 32'(val));
    check_eq("inexact", 32'(bus.out_inexact), 32'(inx));
    check_eq("err", 32'(bus.out_err), 32'(err));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_ready", 32'(bus.in_ready), 32'd0);
      check_eq("hold_value", {22'd0, bus.out_err, bus.out_inexact, bus.out_value},
               32'((err << (W + 1)) | (inx << W) | val));
    end
    // Offer a competing operand during the consume cycle; it must not be taken.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_index  = '0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq("valid_drop", 32'(bus.out_valid), 32'd0);
    check_eq("idle_after_consume", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},   32'(bus.in_ready),    32'd1);
    check_eq({tag, "_valid"},   32'(bus.out_valid),   32'd0);
    check_eq({tag, "_value"},   32'(bus.out_value),   32'd0);
    check_eq({tag, "_inexact"}, 32'(bus.out_inexact), 32'd0);
    check_eq({tag, "_err"},     32'(bus.out_err),     32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_index  = '0;
    bus.in_frac   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(5'sd8,  8'hA5,        0);
    do_op(5'sd4,  8'b1011_0000, 0);
    do_op(5'sd0,  8'h01,        0);
    do_op(-5'sd1, 8'hFF,        0);
    do_op(5'sd9,  8'hFF,        0);
    do_op(-5'sd2, 8'h3C,        0);
    do_op(5'sd3,  8'h7E,        6);

    for (int n = 0; n < 60; n++) begin
      logic [IW-1:0] ridx;
      logic [W-2:0]  rfrac;
      if ($urandom_range(0, 3) == 0)
        ridx = IW'($urandom_range(0, 31));
      else
        ridx = IW'($urandom_range(0, W - 1));
      rfrac = (W-1)'($urandom);
      do_op(ridx, rfrac, int'($urandom_range(0, 3)));
    end

    // Leave a nonzero result in the output registers, then abort mid-shift.
    do_op(5'sd8, 8'hA5, 0);
    bus.in_valid = 1'b1;
    bus.in_index = '0;
    bus.in_frac  = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");
    do_op(5'sd7, 8'h80, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
